// File: rtl/task_dispatch_unit_pkg.sv
// Shared types and constants for the tile's task dispatch path.
package task_dispatch_unit_pkg;

  localparam int unsigned N_THREADS = 8;
  localparam int unsigned THREAD_W  = $clog2(N_THREADS);
  localparam int unsigned CQ_SLOT_W = 6;
  localparam int unsigned TTYPE_W   = 8;
  localparam int unsigned TARGS_W   = 24;
  localparam int unsigned N_TILES   = 4;
  localparam int unsigned STAT_W    = 32;

  // Per-tile enable for serializer/dispatcher statistics.
  localparam logic [N_TILES-1:0] SERIALIZER_LOGGING = {N_TILES{1'b1}};

  typedef logic [THREAD_W-1:0]  thread_id_t;
  typedef logic [CQ_SLOT_W-1:0] cq_slice_slot_t;

  typedef struct packed {
    logic [TTYPE_W-1:0] ttype;
    logic [TARGS_W-1:0] args;
  } task_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } thr_state_t;

endpackage

// File: rtl/task_dispatch_unit_rr_arbiter.sv
// Round-robin arbiter; the search pointer moves past the grant only when advance is strobed.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [$clog2(N)-1:0] grant_idx_c,
  output logic                 grant_valid_c
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d, idx;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    grant_valid_c = 1'b0;
    grant_idx_c   = '0;
    idx           = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr_q + IW'(i);
      if (!grant_valid_c && req[idx]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid_c) begin
      ptr_d = grant_idx_c + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/task_dispatch_unit.sv
// Core-side dispatcher: buffers one task per thread, starts them round-robin, reports finishes, unlocks threads.
// Optional statistics counters are enabled by defining TASK_DISPATCH_STATS_EN.
module task_dispatch_unit
  import task_dispatch_unit_pkg::*;
#(
  parameter int unsigned TILE_ID = 0,
  parameter int unsigned N_THR   = N_THREADS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  task_t                 s_rdata,
  input  cq_slice_slot_t        s_cq_slot,
  input  thread_id_t            s_thread,
  output logic                  start_valid,
  input  logic                  start_ready,
  output task_t                 start_task,
  output thread_id_t            start_thread,
  input  logic                  done_valid,
  output logic                  done_ready,
  input  thread_id_t            done_thread,
  output logic                  finish_valid,
  input  logic                  finish_ready,
  output cq_slice_slot_t        finish_cq_slot,
  output logic                  unlock_valid,
  output thread_id_t            unlock_thread,
  output logic                  proto_err
`ifdef TASK_DISPATCH_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_started,
  output logic [STAT_W-1:0]     stat_finished,
  output logic [STAT_W-1:0]     stat_busy_cycles
`endif
);

  if (N_THR < 2 || (N_THR & (N_THR - 1)) != 0 || N_THR != N_THREADS || TILE_ID >= N_TILES) begin : g_cfg_check
    $error("task_dispatch_unit: unsupported N_THR or TILE_ID");
  end

  thr_state_t     thr_state_q [N_THR];
  thr_state_t     thr_state_d [N_THR];
  task_t          task_q      [N_THR];
  task_t          task_d      [N_THR];
  cq_slice_slot_t slot_q      [N_THR];
  cq_slice_slot_t slot_d      [N_THR];

  logic           finish_valid_q, finish_valid_d;
  thread_id_t     fin_thread_q, fin_thread_d;
  cq_slice_slot_t finish_slot_q, finish_slot_d;
  logic           unlock_valid_q, unlock_valid_d;
  thread_id_t     unlock_thread_q, unlock_thread_d;
  logic           proto_err_q, proto_err_d;

  logic [N_THR-1:0] pend_req;
  thread_id_t       grant_idx;
  logic             grant_valid;

  always_comb begin
    pend_req = '0;
    for (int unsigned i = 0; i < N_THR; i++) begin
      pend_req[i] = (thr_state_q[i] == PEND);
    end
  end

  rr_arbiter #(.N(N_THR)) u_arb (
    .clk           (clk),
    .rstn          (rstn),
    .req           (pend_req),
    .advance       (start_ready),
    .grant_idx_c   (grant_idx),
    .grant_valid_c (grant_valid)
  );

  assign s_ready        = (thr_state_q[s_thread] == IDLE);
  assign start_valid    = grant_valid;
  assign start_thread   = grant_idx;
  assign start_task     = task_q[grant_idx];
  assign done_ready     = !finish_valid_q;
  assign finish_valid   = finish_valid_q;
  assign finish_cq_slot = finish_slot_q;
  assign unlock_valid   = unlock_valid_q;
  assign unlock_thread  = unlock_thread_q;
  assign proto_err      = proto_err_q;

  // Each handshake touches a different thread, so all four can apply in one cycle.
  always_comb begin
    thr_state_d     = thr_state_q;
    task_d          = task_q;
    slot_d          = slot_q;
    finish_valid_d  = finish_valid_q;
    fin_thread_d    = fin_thread_q;
    finish_slot_d   = finish_slot_q;
    unlock_valid_d  = 1'b0;
    unlock_thread_d = unlock_thread_q;
    proto_err_d     = proto_err_q;

    if (s_valid && s_ready) begin
      thr_state_d[s_thread] = PEND;
      task_d[s_thread]      = s_rdata;
      slot_d[s_thread]      = s_cq_slot;
    end

    if (grant_valid && start_ready) begin
      thr_state_d[grant_idx] = RUN;
    end

    if (done_valid && done_ready) begin
      if (thr_state_q[done_thread] == RUN) begin
        thr_state_d[done_thread] = FIN;
        finish_valid_d           = 1'b1;
        fin_thread_d             = done_thread;
        finish_slot_d            = slot_q[done_thread];
      end else begin
        proto_err_d = 1'b1;
      end
    end

    if (finish_valid_q && finish_ready) begin
      thr_state_d[fin_thread_q] = IDLE;
      finish_valid_d            = 1'b0;
      unlock_valid_d            = 1'b1;
      unlock_thread_d           = fin_thread_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      thr_state_q     <= '{default: IDLE};
      task_q          <= '{default: '0};
      slot_q          <= '{default: '0};
      finish_valid_q  <= 1'b0;
      fin_thread_q    <= '0;
      finish_slot_q   <= '0;
      unlock_valid_q  <= 1'b0;
      unlock_thread_q <= '0;
      proto_err_q     <= 1'b0;
    end else begin
      thr_state_q     <= thr_state_d;
      task_q          <= task_d;
      slot_q          <= slot_d;
      finish_valid_q  <= finish_valid_d;
      fin_thread_q    <= fin_thread_d;
      finish_slot_q   <= finish_slot_d;
      unlock_valid_q  <= unlock_valid_d;
      unlock_thread_q <= unlock_thread_d;
      proto_err_q     <= proto_err_d;
    end
  end

`ifdef TASK_DISPATCH_STATS_EN
  localparam logic LOG_EN = SERIALIZER_LOGGING[TILE_ID];

  logic [STAT_W-1:0] started_q, started_d;
  logic [STAT_W-1:0] finished_q, finished_d;
  logic [STAT_W-1:0] busy_q, busy_d;
  logic              any_run;

  // Counters wrap naturally at 2^32.
  always_comb begin
    any_run = 1'b0;
    for (int unsigned i = 0; i < N_THR; i++) begin
      if (thr_state_q[i] == RUN) begin
        any_run = 1'b1;
      end
    end
    started_d  = started_q;
    finished_d = finished_q;
    busy_d     = busy_q;
    if (LOG_EN) begin
      if (grant_valid && start_ready) begin
        started_d = started_q + STAT_W'(1);
      end
      if (finish_valid_q && finish_ready) begin
        finished_d = finished_q + STAT_W'(1);
      end
      if (any_run) begin
        busy_d = busy_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      started_q  <= '0;
      finished_q <= '0;
      busy_q     <= '0;
    end else begin
      started_q  <= started_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
    end
  end

  assign stat_started     = started_q;
  assign stat_finished    = finished_q;
  assign stat_busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_task_dispatch_unit.sv
// Self-checking bench for task_dispatch_unit: directed cycle table, reset sequence, randomized run vs. model.
module tb_task_dispatch_unit;
  import task_dispatch_unit_pkg::*;

  localparam int N = N_THREADS;

  logic           clk = 1'b0;
  logic           rstn;
  logic           s_valid;
  logic           s_ready;
  task_t          s_rdata;
  cq_slice_slot_t s_cq_slot;
  thread_id_t     s_thread;
  logic           start_valid;
  logic           start_ready;
  task_t          start_task;
  thread_id_t     start_thread;
  logic           done_valid;
  logic           done_ready;
  thread_id_t     done_thread;
  logic           finish_valid;
  logic           finish_ready;
  cq_slice_slot_t finish_cq_slot;
  logic           unlock_valid;
  thread_id_t     unlock_thread;
  logic           proto_err;
`ifdef TASK_DISPATCH_STATS_EN
  logic [31:0]    stat_started;
  logic [31:0]    stat_finished;
  logic [31:0]    stat_busy_cycles;
`endif

  always #5 clk = ~clk;

  task_dispatch_unit #(.TILE_ID(0), .N_THR(N)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_rdata        (s_rdata),
    .s_cq_slot      (s_cq_slot),
    .s_thread       (s_thread),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .start_task     (start_task),
    .start_thread   (start_thread),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .done_thread    (done_thread),
    .finish_valid   (finish_valid),
    .finish_ready   (finish_ready),
    .finish_cq_slot (finish_cq_slot),
    .unlock_valid   (unlock_valid),
    .unlock_thread  (unlock_thread),
    .proto_err      (proto_err)
`ifdef TASK_DISPATCH_STATS_EN
    ,
    .stat_started     (stat_started),
    .stat_finished    (stat_finished),
    .stat_busy_cycles (stat_busy_cycles)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic task_t task_of(input int t);
    task_t r;
    r.ttype = TTYPE_W'(t + 8'h40);
    r.args  = TARGS_W'(t * 37 + 5);
    return r;
  endfunction

  function automatic cq_slice_slot_t slot_of(input int t);
    return cq_slice_slot_t'(t * 5 + 2);
  endfunction

  // One row per clock: inputs held for the cycle, outputs expected in that same cycle.
  typedef struct {
    int sv; int st; int sr; int dv; int dt; int fr;
    int e_sr; int e_stv; int e_stt; int e_dr; int e_fv; int e_fthr; int e_uv; int e_ut; int e_perr;
  } vec_t;

  vec_t vecs[$];

  task automatic idle_inputs();
    s_valid      = 1'b0;
    s_thread     = '0;
    s_rdata      = '0;
    s_cq_slot    = '0;
    start_ready  = 1'b0;
    done_valid   = 1'b0;
    done_thread  = '0;
    finish_ready = 1'b0;
  endtask

  // Behavioural model state for the randomized phase
  int             m_st [N];     // 0 free, 1 waiting to start, 2 on core, 3 awaiting CQ
  task_t          m_task [N];
  cq_slice_slot_t m_slot [N];
  int             m_last;
  int             m_fin_thr;
  int             m_fin_q [$];
  int             m_unl;
  int             m_unl_thr;

  initial begin
    rstn = 1'b0;
    idle_inputs();

    // sv st sr dv dt fr | e_sr e_stv e_stt e_dr e_fv e_fthr e_uv e_ut e_perr
    vecs.push_back('{1,3,0,0,0,0, 1,0,0,1,0,0,0,0,0});
    vecs.push_back('{0,3,0,0,0,0, 0,1,3,1,0,0,0,0,0});
    vecs.push_back('{0,3,1,0,0,0, 0,1,3,1,0,0,0,0,0});
    vecs.push_back('{0,3,0,0,0,0, 0,0,0,1,0,0,0,0,0});
    vecs.push_back('{0,3,0,1,3,0, 0,0,0,1,0,0,0,0,0});
    vecs.push_back('{0,3,0,0,0,0, 0,0,0,0,1,3,0,0,0});
    vecs.push_back('{0,3,0,0,0,1, 0,0,0,0,1,3,0,0,0});
    vecs.push_back('{0,3,0,0,0,0, 1,0,0,1,0,0,1,3,0});
    vecs.push_back('{0,3,0,0,0,0, 1,0,0,1,0,0,0,0,0});
    vecs.push_back('{1,0,0,0,0,0, 1,0,0,1,0,0,0,0,0});
    vecs.push_back('{1,1,0,0,0,0, 1,1,0,1,0,0,0,0,0});
    vecs.push_back('{1,2,1,0,0,0, 1,1,0,1,0,0,0,0,0});
    vecs.push_back('{0,0,1,0,0,0, 0,1,1,1,0,0,0,0,0});
    vecs.push_back('{0,0,1,1,0,0, 0,1,2,1,0,0,0,0,0});
    vecs.push_back('{0,0,1,0,0,1, 0,0,0,0,1,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0, 1,0,0,1,0,0,1,0,0});
    vecs.push_back('{1,0,0,0,0,0, 1,0,0,1,0,0,0,0,0});
    vecs.push_back('{1,4,0,0,0,0, 1,1,0,1,0,0,0,0,0});
    vecs.push_back('{0,4,1,0,0,0, 0,1,4,1,0,0,0,0,0});
    vecs.push_back('{0,4,1,0,0,0, 0,1,0,1,0,0,0,0,0});
    vecs.push_back('{0,4,0,0,0,0, 0,0,0,1,0,0,0,0,0});
    vecs.push_back('{0,1,0,1,1,0, 0,0,0,1,0,0,0,0,0});
    for (int k = 0; k < 5; k++) vecs.push_back('{0,1,0,1,2,0, 0,0,0,0,1,1,0,0,0});
    vecs.push_back('{0,1,0,1,2,1, 0,0,0,0,1,1,0,0,0});
    vecs.push_back('{0,2,0,1,2,0, 0,0,0,1,0,0,1,1,0});
    vecs.push_back('{0,2,0,0,0,1, 0,0,0,0,1,2,0,0,0});
    vecs.push_back('{0,2,0,0,0,0, 1,0,0,1,0,0,1,2,0});
    vecs.push_back('{0,7,0,1,7,0, 1,0,0,1,0,0,0,0,0});
    vecs.push_back('{0,7,0,0,0,0, 1,0,0,1,0,0,0,0,1});
    vecs.push_back('{0,7,0,0,0,0, 1,0,0,1,0,0,0,0,1});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.start_valid", start_valid, 0);
    chk("rst.finish_valid", finish_valid, 0);
    chk("rst.unlock_valid", unlock_valid, 0);
    chk("rst.proto_err", proto_err, 0);
    chk("rst.s_ready", s_ready, 1);
    chk("rst.done_ready", done_ready, 1);
    rstn = 1'b1;

    // Directed cycle table
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk);
      #1;
      s_valid      = (v.sv != 0);
      s_thread     = thread_id_t'(v.st);
      s_rdata      = task_of(v.st);
      s_cq_slot    = slot_of(v.st);
      start_ready  = (v.sr != 0);
      done_valid   = (v.dv != 0);
      done_thread  = thread_id_t'(v.dt);
      finish_ready = (v.fr != 0);
      @(negedge clk);
      chk($sformatf("row%0d.s_ready", i), s_ready, 64'(v.e_sr));
      chk($sformatf("row%0d.start_valid", i), start_valid, 64'(v.e_stv));
      if (v.e_stv != 0) begin
        chk($sformatf("row%0d.start_thread", i), start_thread, 64'(v.e_stt));
        chk($sformatf("row%0d.start_task", i), start_task, task_of(v.e_stt));
      end
      chk($sformatf("row%0d.done_ready", i), done_ready, 64'(v.e_dr));
      chk($sformatf("row%0d.finish_valid", i), finish_valid, 64'(v.e_fv));
      if (v.e_fv != 0) begin
        chk($sformatf("row%0d.finish_cq_slot", i), finish_cq_slot, slot_of(v.e_fthr));
      end
      chk($sformatf("row%0d.unlock_valid", i), unlock_valid, 64'(v.e_uv));
      if (v.e_uv != 0) begin
        chk($sformatf("row%0d.unlock_thread", i), unlock_thread, 64'(v.e_ut));
      end
      chk($sformatf("row%0d.proto_err", i), proto_err, 64'(v.e_perr));
    end

    // Bring threads 5 and 6 onto the core too (0 and 4 already running), then reset mid-run
    @(posedge clk); #1; idle_inputs(); s_valid = 1'b1; s_thread = 5; s_rdata = task_of(5); s_cq_slot = slot_of(5);
    @(posedge clk); #1; s_thread = 6; s_rdata = task_of(6); s_cq_slot = slot_of(6);
    @(posedge clk); #1; s_valid = 1'b0; start_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; start_ready = 1'b0; s_thread = 5;
    @(negedge clk);
    chk("pre_rst.s_ready_busy", s_ready, 0);
    chk("pre_rst.start_valid", start_valid, 0);
    chk("pre_rst.proto_err", proto_err, 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("async_rst.start_valid", start_valid, 0);
    chk("async_rst.finish_valid", finish_valid, 0);
    chk("async_rst.unlock_valid", unlock_valid, 0);
    chk("async_rst.proto_err", proto_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int t = 0; t < N; t++) begin
      s_thread = thread_id_t'(t);
      #1;
      chk($sformatf("post_rst.s_ready%0d", t), s_ready, 1);
    end
`ifdef TASK_DISPATCH_STATS_EN
    chk("post_rst.stat_started", stat_started, 0);
    chk("post_rst.stat_finished", stat_finished, 0);
    chk("post_rst.stat_busy_cycles", stat_busy_cycles, 0);
`endif

    // Randomized traffic against the behavioural model
    for (int t = 0; t < N; t++) begin
      m_st[t] = 0;
      m_task[t] = '0;
      m_slot[t] = '0;
    end
    m_last = N - 1;
    m_fin_q.delete();
    m_fin_thr = 0;
    m_unl = 0;
    m_unl_thr = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int cand [$];
      int run [$];
      int g;
      bit e_sr;
      bit e_stv;
      bit fin_pre;
      @(posedge clk);
      #1;
      idle_inputs();
      cand.delete();
      run.delete();
      for (int t = 0; t < N; t++) begin
        if (m_st[t] == 0 && !(m_unl != 0 && m_unl_thr == t)) cand.push_back(t);
        if (m_st[t] == 2) run.push_back(t);
      end
      s_thread  = thread_id_t'($urandom_range(0, N - 1));
      s_rdata   = task_t'($urandom);
      s_cq_slot = cq_slice_slot_t'($urandom);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        s_valid  = 1'b1;
        s_thread = thread_id_t'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      start_ready = ($urandom_range(0, 3) != 0);
      if (run.size() > 0 && $urandom_range(0, 1) == 1) begin
        done_valid  = 1'b1;
        done_thread = thread_id_t'(run[$urandom_range(0, run.size() - 1)]);
      end
      finish_ready = ($urandom_range(0, 2) != 0);

      @(negedge clk);
      e_sr  = (m_st[int'(s_thread)] == 0);
      e_stv = 1'b0;
      g     = 0;
      for (int k = 1; k <= N; k++) begin
        if (!e_stv && m_st[(m_last + k) % N] == 1) begin
          e_stv = 1'b1;
          g     = (m_last + k) % N;
        end
      end
      fin_pre = (m_fin_q.size() != 0);
      chk("rnd.s_ready", s_ready, 64'(e_sr));
      chk("rnd.start_valid", start_valid, 64'(e_stv));
      if (e_stv) begin
        chk("rnd.start_thread", start_thread, 64'(g));
        chk("rnd.start_task", start_task, m_task[g]);
      end
      chk("rnd.done_ready", done_ready, 64'(!fin_pre));
      chk("rnd.finish_valid", finish_valid, 64'(fin_pre));
      if (fin_pre) chk("rnd.finish_cq_slot", finish_cq_slot, m_slot[m_fin_q[0]]);
      chk("rnd.unlock_valid", unlock_valid, 64'(m_unl));
      if (m_unl != 0) chk("rnd.unlock_thread", unlock_thread, 64'(m_unl_thr));
      chk("rnd.proto_err", proto_err, 0);

      m_unl = 0;
      if (fin_pre && finish_ready) begin
        m_fin_thr = m_fin_q.pop_front();
        m_st[m_fin_thr] = 0;
        m_unl = 1;
        m_unl_thr = m_fin_thr;
      end
      if (done_valid && !fin_pre) begin
        m_st[int'(done_thread)] = 3;
        m_fin_q.push_back(int'(done_thread));
      end
      if (e_stv && start_ready) begin
        m_st[g] = 2;
        m_last  = g;
      end
      if (s_valid && e_sr) begin
        m_st[int'(s_thread)]   = 1;
        m_task[int'(s_thread)] = s_rdata;
        m_slot[int'(s_thread)] = s_cq_slot;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
